// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Registers decoded operands and control from ID, forwards newer EX/MEM and
// MEM/WB results onto the ALU operands, and converts a load-use hazard into
// a single self-inserted bubble that is counted in bubble_cnt_o.
// Optional build macro: IDEX_FORWARD_EN enables forwarding and hazard
// detection; without it operands come straight from the registered values.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] rs1_data_i,
   input  logic [DATA_W-1:0] rs2_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [REG_W-1:0]  rs1_addr_i,
   input  logic [REG_W-1:0]  rs2_addr_i,
   input  logic [REG_W-1:0]  rd_addr_i,
   input  logic [2:0]        alu_ctrl_i,
   input  logic              alu_src_i,
   input  logic              reg_write_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic              mem_to_reg_i,
   input  logic              exmem_reg_write_i,
   input  logic [REG_W-1:0]  exmem_rd_i,
   input  logic [DATA_W-1:0] exmem_data_i,
   input  logic              memwb_reg_write_i,
   input  logic [REG_W-1:0]  memwb_rd_i,
   input  logic [DATA_W-1:0] memwb_data_i,
   output logic [DATA_W-1:0] alu_data1_o,
   output logic [DATA_W-1:0] alu_data2_o,
   output logic [2:0]        alu_ctrl_o,
   output logic [DATA_W-1:0] store_data_o,
   output logic [REG_W-1:0]  rd_addr_o,
   output logic              reg_write_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic              mem_to_reg_o,
   output logic              valid_o,
   output logic              hazard_o,
   output logic [15:0]       bubble_cnt_o
);

   // A bubble is an add of zeros with every side effect disabled.
   localparam logic [2:0] ALU_ADD = 3'b101;

   logic [DATA_W-1:0] rs1_data_r, rs2_data_r, imm_r;
   logic [REG_W-1:0]  rs1_addr_r, rs2_addr_r, rd_addr_r;
   logic [2:0]        alu_ctrl_r;
   logic              alu_src_r, reg_write_r, mem_read_r, mem_write_r, mem_to_reg_r, valid_r;
   logic [15:0]       bubble_cnt_r;
   logic              hazard_s;
   logic [DATA_W-1:0] fwd1_s, fwd2_s;

`ifdef IDEX_FORWARD_EN
   // Youngest producer wins: EX/MEM beats MEM/WB; x0 is never forwarded.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [REG_W-1:0]  src,
      input logic [DATA_W-1:0] raw,
      input logic              ex_we,
      input logic [REG_W-1:0]  ex_rd,
      input logic [DATA_W-1:0] ex_data,
      input logic              wb_we,
      input logic [REG_W-1:0]  wb_rd,
      input logic [DATA_W-1:0] wb_data
   );
      logic [DATA_W-1:0] sel;
      if (ex_we && (ex_rd != {REG_W{1'b0}}) && (ex_rd == src)) begin
         sel = ex_data;
      end else if (wb_we && (wb_rd != {REG_W{1'b0}}) && (wb_rd == src)) begin
         sel = wb_data;
      end else begin
         sel = raw;
      end
      return sel;
   endfunction

   // Load in EX whose destination is read by the ID instruction (rs2 is
   // checked even when unused); independent of stall/flush by design.
   assign hazard_s = valid_r & mem_read_r & (rd_addr_r != {REG_W{1'b0}}) & valid_i &
                     ((rd_addr_r == rs1_addr_i) | (rd_addr_r == rs2_addr_i));

   // Operand forwarding muxes, combinational from the downstream stages.
   always_comb begin
      fwd1_s = fwd_sel(rs1_addr_r, rs1_data_r, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                       memwb_reg_write_i, memwb_rd_i, memwb_data_i);
      fwd2_s = fwd_sel(rs2_addr_r, rs2_data_r, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                       memwb_reg_write_i, memwb_rd_i, memwb_data_i);
   end
`else
   // Without forwarding, software schedules NOPs; downstream results and
   // registered source addresses are intentionally ignored.
   logic unused_fwd_s;
   assign unused_fwd_s = ^{exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
                           rs1_addr_r, rs2_addr_r};
   assign hazard_s = 1'b0;

   // Operands pass straight from the registered register-file reads.
   always_comb begin
      fwd1_s = rs1_data_r;
      fwd2_s = rs2_data_r;
   end
`endif

   // Stage register: reset > stall > flush/hazard bubble > normal capture.
   always_ff @(posedge clk_i) begin
      if (rst_i || (!stall_i && (flush_i || hazard_s))) begin
         rs1_data_r   <= {DATA_W{1'b0}};
         rs2_data_r   <= {DATA_W{1'b0}};
         imm_r        <= {DATA_W{1'b0}};
         rs1_addr_r   <= {REG_W{1'b0}};
         rs2_addr_r   <= {REG_W{1'b0}};
         rd_addr_r    <= {REG_W{1'b0}};
         alu_ctrl_r   <= ALU_ADD;
         alu_src_r    <= 1'b0;
         reg_write_r  <= 1'b0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= 1'b0;
         mem_to_reg_r <= 1'b0;
         valid_r      <= 1'b0;
      end else if (!stall_i) begin
         rs1_data_r   <= rs1_data_i;
         rs2_data_r   <= rs2_data_i;
         imm_r        <= imm_i;
         rs1_addr_r   <= rs1_addr_i;
         rs2_addr_r   <= rs2_addr_i;
         rd_addr_r    <= rd_addr_i;
         alu_ctrl_r   <= alu_ctrl_i;
         alu_src_r    <= alu_src_i;
         reg_write_r  <= reg_write_i;
         mem_read_r   <= mem_read_i;
         mem_write_r  <= mem_write_i;
         mem_to_reg_r <= mem_to_reg_i;
         valid_r      <= valid_i;
      end else begin
         valid_r      <= valid_r;
      end
   end

   // Saturating count of hazard bubbles; flush bubbles are not counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bubble_cnt_r <= 16'd0;
      end else if (!stall_i && !flush_i && hazard_s && (bubble_cnt_r != 16'hFFFF)) begin
         bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end

   assign alu_data1_o  = fwd1_s;
   assign store_data_o = fwd2_s;
   assign alu_data2_o  = alu_src_r ? imm_r : fwd2_s;
   assign alu_ctrl_o   = alu_ctrl_r;
   assign rd_addr_o    = rd_addr_r;
   assign reg_write_o  = reg_write_r;
   assign mem_read_o   = mem_read_r;
   assign mem_write_o  = mem_write_r;
   assign mem_to_reg_o = mem_to_reg_r;
   assign valid_o      = valid_r;
   assign hazard_o     = hazard_s;
   assign bubble_cnt_o = bubble_cnt_r;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use bubble insertion, sitting directly upstream of the ALU in the 5-stage pipeline. Captures decoded operands and control from ID each cycle and presents the final ALU operands (`alu_data1_o`, `alu_data2_o`) and `alu_ctrl_o` to the ALU. Operands are selected from EX/MEM and MEM/WB results when those are newer than the register-file values. Detects load-use hazards, reports them to the front end, and self-inserts a bubble.

## Interface
- `DATA_W`, 32, datapath width (the ALU is fixed at 32).
- `REG_W`, 5, register address width.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `stall_i` in 1: hold all stage state.
- `flush_i` in 1: load a bubble (branch or exception squash).
- `valid_i` in 1: the ID instruction is real.
- `rs1_data_i`, `rs2_data_i`, `imm_i` in DATA_W: register-file reads and sign-extended immediate.
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i` in REG_W: source and destination registers.
- `alu_ctrl_i` in 3: ALU op (000 and, 001 xor, 010 sll, 011 sub, 100 mul, 101 add, 110 sra).
- `alu_src_i` in 1: 1 selects `imm` as operand 2.
- `reg_write_i`, `mem_read_i`, `mem_write_i`, `mem_to_reg_i` in 1: downstream control.
- `exmem_reg_write_i` in 1, `exmem_rd_i` in REG_W, `exmem_data_i` in DATA_W: EX/MEM result.
- `memwb_reg_write_i` in 1, `memwb_rd_i` in REG_W, `memwb_data_i` in DATA_W: MEM/WB writeback.
- `alu_data1_o`, `alu_data2_o` out DATA_W: ALU operands.
- `alu_ctrl_o` out 3: registered ALU op.
- `store_data_o` out DATA_W: forwarded rs2, for stores.
- `rd_addr_o` out REG_W; `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `valid_o` out 1: registered control.
- `hazard_o` out 1: load-use hazard, combinational; front end must hold PC and IF/ID.
- `bubble_cnt_o` out 16: count of hazard bubbles inserted.

## Operation
- Update priority per edge: `rst_i` > `stall_i` > `flush_i` > `hazard_o` > normal capture.
- Reset and bubble state: all data and addresses 0, `alu_ctrl_o`=101 (add), all control outputs and `valid_o`=0.
- On reset, `bubble_cnt_o`=0 and `hazard_o`=0.
- Normal capture: every ID input is registered unchanged.
- Stall: all registers, including the counter, hold their values. `hazard_o` is still evaluated.
- Hazard:
  - `hazard_o` = `valid_o & mem_read_o & (rd_addr_o!=0) & valid_i & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i)`.
  - Detection is conservative: it ignores whether the ID instruction actually uses rs2.
  - A hazard-caused bubble load (`hazard_o & !stall_i & !flush_i`) increments `bubble_cnt_o`. The counter saturates at 16'hFFFF.
  - Flush bubbles are not counted.
- Forwarding, per registered source `rsN`:
  - If `exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==rsN`, use `exmem_data_i`.
  - Else if the same condition holds for MEM/WB, use `memwb_data_i`.
  - Else use the registered register-file data.
  - Register x0 is never forwarded.
- Operand outputs:
  - `alu_data1_o` = forwarded rs1.
  - `store_data_o` = forwarded rs2.
  - `alu_data2_o` = `alu_src` ? registered imm : forwarded rs2.

## Timing
- Latency is one cycle from ID inputs to registered outputs.
- Forwarding muxes are combinational from EX/MEM and MEM/WB inputs to the operand outputs in the same cycle.
- `hazard_o` is combinational from the ID inputs and registered state in the same cycle. It must not depend on `stall_i` or `flush_i`.
- A load followed by a dependent instruction gives exactly one bubble.
  - Next cycle the load has left EX, so `hazard_o` drops.
  - The dependent instruction, still held in ID, is then captured.
  - It receives the load data via MEM/WB forwarding.
- `rst_i` asserted mid-operation overrides stall and flush on that edge. Outputs reach reset values after the edge.

## Configuration
- `IDEX_FORWARD_EN` defined:
  - Forwarding muxes present as described.
  - `hazard_o` and bubble insertion active.
- Not defined:
  - Operands come straight from the registered register-file data and imm.
  - `hazard_o` tied to 0; no hazard bubbles, and `bubble_cnt_o` stays 0.
  - Forwarding inputs are unused; software must insert NOPs.
  - Stall and flush behave identically in both builds.

## Test plan
- Reset, then release with `valid_i=1` and all inputs 0 -> after reset `valid_o=0`, `alu_ctrl_o=101`, `bubble_cnt_o=0`; the next edge captures `valid_i`, so `valid_o=1`.
- Registered rs1=x5, `exmem_rd=5`, `exmem_data=0x11`, `memwb_rd=5`, `memwb_data=0x22`, `reg_write` on both -> `alu_data1_o=0x11`. Deassert `exmem_reg_write_i` -> `alu_data1_o=0x22`.
- rs2=x0, `exmem_rd=0`, `exmem_data=0xDEAD`, `rs2_data=0`, `alu_src=0` -> `alu_data2_o=0`.
- Registered `lw` with rd=x7, ID `add` with rs1=x7 -> `hazard_o=1`; next edge `valid_o=0`, `bubble_cnt_o=1`; `hazard_o=0`, and the following edge captures the `add`.
- Hazard present with `stall_i=1` -> state held, counter unchanged. Then `flush_i=1` with hazard -> bubble loaded, counter unchanged.
- Build without `IDEX_FORWARD_EN` -> forwarding and hazard scenarios yield the raw `rs1_data` and `hazard_o=0`.
